// File: rtl/zx_pager.sv
// Z80 memory pager: 48K/128K/+3/extended-RAM banking via 7FFD/1FFD/DFFD.
// DivMMC overlay (E3 port, automap FSM) is built only with ZX_PAGER_DIVMMC_EN defined.
module zx_pager #(
  parameter int RAM_PAGE_BITS = 3,
  parameter int DIV_PAGE_BITS = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ce,
  input  logic [1:0]                model,
  input  logic                      nomap,
  input  logic                      iorq,
  input  logic                      mreq,
  input  logic                      wr,
  input  logic                      rd,
  input  logic                      m1,
  input  logic [15:0]               a,
  input  logic [7:0]                d,
  output logic [RAM_PAGE_BITS+14:0] memA,
  output logic                      memWe,
  output logic [15:0]               romA,
  output logic [1:0]                sel,
  output logic                      vduPage,
  output logic                      cn,
  output logic                      mapped
);

  localparam int AW = RAM_PAGE_BITS + 15;
  localparam int RB = RAM_PAGE_BITS;

  typedef logic [RB-1:0]            bank_t;
  typedef logic [DIV_PAGE_BITS-1:0] page_t;

  logic [7:0] p7ffd;
  logic [2:0] p1ffd;
  bank_t      bank;
  bank_t      slot_bank;
  logic [2:0] sp_bank;
  logic [1:0] slot;
  logic [1:0] rom_page;
  logic       plus3, special, main_ram, ram_target;
  logic       wr_io, port_en, dec7ffd, dec1ffd;
  logic       map, mapram;
  page_t      div_page;
  logic       unused_ok;

  assign slot    = a[15:14];
  assign plus3   = model[1];
  assign special = plus3 && p1ffd[0];
  assign wr_io   = ce && !iorq && !wr;
  assign port_en = wr_io && !p7ffd[5] && (model != 2'd0);
  assign dec7ffd = !a[1] && (plus3 ? (a[15:14] == 2'b01) : !a[15]);
  assign dec1ffd = plus3 && !a[1] && (a[15:12] == 4'b0001);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p7ffd <= '0;
      p1ffd <= '0;
    end else if (port_en) begin
      if (dec7ffd) p7ffd <= d;
      if (dec1ffd) p1ffd <= d[2:0];
    end
  end

  generate
    if (RB > 3) begin : g_dffd
      logic [RB-4:0] pdffd;
      always_ff @(posedge clock or posedge reset) begin
        if (reset)
          pdffd <= '0;
        else if (port_en && !a[1] && (a[15:12] == 4'b1101))
          pdffd <= d[RB-4:0];
      end
      assign bank = {pdffd, p7ffd[2:0]};
    end else begin : g_nodffd
      assign bank = p7ffd[2:0];
    end
  endgenerate

  always_comb begin
    case (model)
      2'd0:    rom_page = 2'b11;
      2'd1:    rom_page = {1'b1, p7ffd[4]};
      default: rom_page = {p1ffd[2], p7ffd[4]};
    endcase
  end

  // +3 all-RAM layouts: 0123 / 4567 / 4563 / 4763
  always_comb begin
    sp_bank = 3'd0;
    case (p1ffd[2:1])
      2'd0:    sp_bank = {1'b0, slot};
      2'd1:    sp_bank = {1'b1, slot};
      2'd2:    sp_bank = (slot == 2'd3) ? 3'd3 : {1'b1, slot};
      default: begin
        case (slot)
          2'd0:    sp_bank = 3'd4;
          2'd1:    sp_bank = 3'd7;
          2'd2:    sp_bank = 3'd6;
          default: sp_bank = 3'd3;
        endcase
      end
    endcase
  end

  always_comb begin
    slot_bank = '0;
    if (special)
      slot_bank = bank_t'(sp_bank);
    else begin
      case (slot)
        2'd1:    slot_bank = bank_t'(3'd5);
        2'd2:    slot_bank = bank_t'(3'd2);
        2'd3:    slot_bank = bank;
        default: slot_bank = '0;
      endcase
    end
  end

  assign main_ram = special || (slot != 2'd0);

`ifdef ZX_PAGER_DIVMMC_EN
  typedef enum logic [1:0] {AM_OFF, AM_PEND_ON, AM_ON, AM_PEND_OFF} am_t;

  am_t        am_state, am_next;
  logic [7:0] divE3;
  logic       fetch, hit_entry, hit_exit, hit_3d;

  assign fetch     = !mreq && !m1 && (rom_page == 2'b11);
  assign hit_entry = (a == 16'h0000) || (a == 16'h0008) || (a == 16'h0038) ||
                     (a == 16'h0066) || (a == 16'h04C6) || (a == 16'h0562);
  assign hit_exit  = (a[15:3] == 13'h03FF);
  assign hit_3d    = (a[15:8] == 8'h3D);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      am_state <= AM_OFF;
      divE3    <= '0;
    end else begin
      am_state <= am_next;
      if (wr_io && (a[7:0] == 8'hE3))
        divE3 <= {d[7], d[6] | divE3[6], d[5:0]};
    end
  end

  always_comb begin
    am_next = am_state;
    if (ce && fetch) begin
      if (hit_3d)
        am_next = AM_ON;
      else if (hit_entry) begin
        case (am_state)
          AM_OFF:      am_next = AM_PEND_ON;
          AM_PEND_OFF: am_next = AM_ON;
          default:     ;
        endcase
      end else if (hit_exit) begin
        case (am_state)
          AM_ON:      am_next = AM_PEND_OFF;
          AM_PEND_ON: am_next = AM_OFF;
          default:    ;
        endcase
      end
    end else if (ce && m1) begin
      case (am_state)
        AM_PEND_ON:  am_next = AM_ON;
        AM_PEND_OFF: am_next = AM_OFF;
        default:     ;
      endcase
    end
  end

  // A 3Dxx fetch maps itself, ahead of the registered state.
  assign map = !special &&
               (divE3[7] || (!nomap && ((am_state == AM_ON) || (am_state == AM_PEND_OFF) ||
                                        (fetch && hit_3d))));
  assign mapram    = divE3[6];
  assign div_page  = divE3[DIV_PAGE_BITS-1:0];
  assign unused_ok = ^{rd, p7ffd[7:6], divE3};
`else
  assign map       = 1'b0;
  assign mapram    = 1'b0;
  assign div_page  = '0;
  assign unused_ok = ^{rd, p7ffd[7:6], m1, nomap};
`endif

  function automatic logic [AW-1:0] div_addr(input page_t pg, input logic [12:0] off);
    logic [AW-1:0] r;
    r                     = '0;
    r[AW-1]               = 1'b1;
    r[13 +: DIV_PAGE_BITS] = pg;
    r[12:0]               = off;
    return r;
  endfunction

  always_comb begin
    memA       = {1'b0, slot_bank, a[13:0]};
    sel        = 2'd1;
    ram_target = 1'b0;
    if (map && (slot == 2'd0)) begin
      if (!a[13]) begin
        if (mapram) begin
          memA = div_addr(page_t'(3), a[12:0]);
          sel  = 2'd0;
        end else begin
          sel = 2'd2;
        end
      end else begin
        memA       = div_addr(div_page, a[12:0]);
        sel        = 2'd0;
        ram_target = !(mapram && (div_page == page_t'(3)));
      end
    end else if (main_ram) begin
      sel        = 2'd0;
      ram_target = 1'b1;
    end
    memWe = !(!mreq && !wr && ram_target);
  end

  always_comb begin
    case (model)
      2'd0:    cn = (slot == 2'd1);
      2'd1:    cn = (slot == 2'd1) || ((slot == 2'd3) && bank[0]);
      default: cn = main_ram && ((slot_bank >> 2) == bank_t'(1));
    endcase
  end

  assign romA    = {rom_page, a[13:0]};
  assign vduPage = p7ffd[3];
  assign mapped  = map;

endmodule
